// File: rtl/maxnet_pkg.sv
// Shared helpers for the Maxnet processing-logic units: width derivation and Q-format constants.
package maxnet_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Tree output width: full product minus dropped fraction, plus one growth bit per tree level.
  function automatic int calc_acc_w(input int n_ch, input int data_w, input int frac_w);
    return 2 * data_w - frac_w + clog2(n_ch);
  endfunction

  // The value 1.0 in Q(data_w-frac_w).frac_w.
  function automatic longint q_one(input int frac_w);
    return longint'(1) << frac_w;
  endfunction

  // Largest positive value representable in data_w signed bits.
  function automatic longint sat_max(input int data_w);
    return (longint'(1) << (data_w - 1)) - 1;
  endfunction

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/plu_relu_sat.sv
// ReLU followed by saturation to the positive range of the output word.
module plu_relu_sat
  import maxnet_pkg::*;
#(
  parameter int ACC_W  = 34,
  parameter int DATA_W = 16
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic        [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_W));

  // Negative sums clamp to zero, oversized positive sums clamp to SAT_MAX.
  always_comb begin
    y = sum[DATA_W-1:0];
    if (sum[ACC_W-1]) begin
      y = '0;
    end else if (sum > SAT_MAX) begin
      y = SAT_MAX[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/maxnet_plu_pipe.sv
// One Maxnet neuron: y = sat(ReLU(sum a_i*w_i)) as a stallable pipeline
// (product regs, registered adder tree, output reg) with runtime-loadable weights.
module maxnet_plu_pipe
  import maxnet_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_load,
  input  logic [N_CH*DATA_W-1:0]   w_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_act,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_act,
  output logic                     out_nz
);

  localparam int L      = clog2(N_CH);
  localparam int PROD_W = 2 * DATA_W - FRAC_W;
  localparam int ACC_W  = calc_acc_w(N_CH, DATA_W, FRAC_W);

  if (!is_pow2_ge2(N_CH)) begin : g_bad_n_ch
    $error("maxnet_plu_pipe: N_CH must be a power of 2 and >= 2");
  end
  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac_w
    $error("maxnet_plu_pipe: FRAC_W must satisfy 0 <= FRAC_W < DATA_W");
  end

  // vld[0] = product stage, vld[1..L] = tree levels, vld[L+1] = output register
  logic [L+1:0]             vld;
  logic                     adv;
  logic [N_CH*DATA_W-1:0]   w_reg;
  logic signed [ACC_W-1:0]  tree_sum;
  logic [DATA_W-1:0]        sat_y;

  assign adv       = !vld[L+1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[L+1];

  // Signed product with the fraction dropped by floor (arithmetic shift).
  function automatic logic signed [PROD_W-1:0] mul_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] w);
    logic signed [2*DATA_W-1:0] full;
    full = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{w[DATA_W-1]}}, w});
    return full[2*DATA_W-1:FRAC_W];
  endfunction

  // Weight registers; loads are honoured even while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg <= '0;
    end else if (w_load) begin
      w_reg <= w_in;
    end
  end

  // Valid bits shift together on advance; empty slots become bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[L:0], in_valid};
    end
  end

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int NW = PROD_W + l;
    localparam int NN = N_CH >> l;
    logic signed [NW-1:0] node [NN];

    if (l == 0) begin : g_mul
      // Capture products of an accepted sample against the weights held before this edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NN; i++) node[i] <= '0;
        end else if (adv && in_valid) begin
          for (int i = 0; i < NN; i++)
            node[i] <= mul_q(in_act[i*DATA_W +: DATA_W], w_reg[i*DATA_W +: DATA_W]);
        end
      end
    end else begin : g_add
      // Pairwise sums, each operand sign-extended by one bit so the level cannot overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < NN; j++) node[j] <= '0;
        end else if (adv && vld[l-1]) begin
          for (int j = 0; j < NN; j++)
            node[j] <= {g_lvl[l-1].node[2*j][NW-2],   g_lvl[l-1].node[2*j]} +
                       {g_lvl[l-1].node[2*j+1][NW-2], g_lvl[l-1].node[2*j+1]};
        end
      end
    end
  end

  assign tree_sum = g_lvl[L].node[0];

  plu_relu_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_relu_sat (
    .sum (tree_sum),
    .y   (sat_y)
  );

  // Output register; holds its last value while no valid result is arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_act <= '0;
      out_nz  <= 1'b0;
    end else if (adv && vld[L]) begin
      out_act <= sat_y;
      out_nz  <= |sat_y;
    end
  end

endmodule
